// File: rtl/barrido_display.sv
// Signed product to BCD (sequential double-dabble, one shift per clock) with a
// time-multiplexed scan of the digits onto a shared bus and one-cold anodes.
module barrido_display #(
    parameter int ANCHO_DATO   = 16,
    parameter int NUM_DIGITOS  = 5,
    parameter int DIV_REFRESCO = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ANCHO_DATO-1:0]  producto,
    input  logic                   inicio,
    output logic                   ocupado,
    output logic                   listo,
    output logic                   negativo,
    output logic [3:0]             digito,
    output logic [NUM_DIGITOS-1:0] anodos
);

    localparam int ANCHO_BCD = 4 * NUM_DIGITOS;
    localparam int ANCHO_ITER = (ANCHO_DATO > 1) ? $clog2(ANCHO_DATO) : 1;
    localparam int ANCHO_REF = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
    localparam int ANCHO_IDX = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
    localparam logic [ANCHO_DATO-1:0] UNO_DATO = ANCHO_DATO'(1);
    localparam logic [NUM_DIGITOS-1:0] ANODOS_RST = {{(NUM_DIGITOS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {REPOSO, CONVIERTE, FIN} estado_t;

    estado_t estado, estado_sig;

    logic                   signo;
    logic [ANCHO_DATO-1:0]  mag;
    logic [ANCHO_DATO-1:0]  mag_in;
    logic [ANCHO_BCD-1:0]   bcd;
    logic [ANCHO_BCD-1:0]   bcd_aj;
    logic [ANCHO_BCD-1:0]   disp;
    logic [ANCHO_BCD-1:0]   disp_sig;
    logic [ANCHO_ITER-1:0]  iter;
    logic                   ultima;

    logic [ANCHO_REF-1:0]   ref_cnt;
    logic                   ref_fin;
    logic [ANCHO_IDX-1:0]   idx;
    logic [ANCHO_IDX-1:0]   idx_sig;
    logic [NUM_DIGITOS-1:0] anod_sig;
    logic [3:0]             digito_sig;

    // The most negative input maps to 2^(ANCHO_DATO-1), which still fits unsigned.
    assign mag_in = producto[ANCHO_DATO-1] ? (~producto + UNO_DATO) : producto;
    assign ultima = (iter == ANCHO_ITER'(ANCHO_DATO - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) estado <= REPOSO;
        else     estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:    if (inicio) estado_sig = CONVIERTE;
            CONVIERTE: if (ultima) estado_sig = FIN;
            FIN:       estado_sig = REPOSO;
            default:   estado_sig = REPOSO;
        endcase
    end

    always_comb begin
        ocupado = (estado != REPOSO);
    end

    always_comb begin
        bcd_aj = bcd;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_aj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Displayed digits only ever change as a whole, at the FIN edge.
    assign disp_sig = (estado == FIN) ? bcd : disp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signo    <= 1'b0;
            mag      <= '0;
            bcd      <= '0;
            iter     <= '0;
            disp     <= '0;
            negativo <= 1'b0;
            listo    <= 1'b0;
        end else begin
            listo <= 1'b0;
            disp  <= disp_sig;
            case (estado)
                REPOSO: begin
                    if (inicio) begin
                        signo <= producto[ANCHO_DATO-1];
                        mag   <= mag_in;
                        bcd   <= '0;
                        iter  <= '0;
                    end
                end
                CONVIERTE: begin
                    bcd  <= {bcd_aj[ANCHO_BCD-2:0], mag[ANCHO_DATO-1]};
                    mag  <= {mag[ANCHO_DATO-2:0], 1'b0};
                    iter <= iter + ANCHO_ITER'(1);
                end
                FIN: begin
                    negativo <= signo;
                    listo    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ref_fin = (ref_cnt == ANCHO_REF'(DIV_REFRESCO - 1));

    always_comb begin
        idx_sig = idx;
        if (ref_fin) begin
            if (idx == ANCHO_IDX'(NUM_DIGITOS - 1)) idx_sig = '0;
            else                                    idx_sig = idx + ANCHO_IDX'(1);
        end
    end

    // Anode and digit are both derived from the next index and next digits so
    // they always agree, even on the edge where new digits are loaded.
    always_comb begin
        anod_sig   = '1;
        digito_sig = 4'd0;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (idx_sig == ANCHO_IDX'(i)) begin
                anod_sig[i] = 1'b0;
                digito_sig  = disp_sig[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= '0;
            anodos  <= ANODOS_RST;
            digito  <= 4'd0;
        end else begin
            ref_cnt <= ref_fin ? '0 : ref_cnt + ANCHO_REF'(1);
            idx     <= idx_sig;
            anodos  <= anod_sig;
            digito  <= digito_sig;
        end
    end

endmodule
